instruction_fetch: RTL and testbench

- Front-end stage of the 8-bit CPU; sits directly upstream of the opcode decoder/control unit.
- Owns the program counter and fetches one 8-bit instruction at a time from instruction memory over a req/valid handshake.
- Holds the fetched instruction in an instruction register and presents opcode and register fields to decode/control.
- Accepts stall back-pressure and a PC redirect (jump/branch) from downstream.

---
 rtl/instruction_fetch.sv | 165 ++++++++++++++++
 tb/tb_instruction_fetch.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Front-end stage of the 8-bit CPU. It owns the program counter and fetches
// one 8-bit instruction at a time from instruction memory. The fetched
// instruction is held in an instruction register, and its opcode and register
// fields are presented to decode/control. Downstream can stall the held
// instruction or redirect the PC.
//
// Optional feature: define FETCH_PERF_CNT_EN to add the fetch_count and
// stall_count performance counters. They saturate at 16'hFFFF.
//
// Ports:
//   clk          in   system clock, all state changes on the rising edge
//   rst          in   synchronous active-high reset
//   imem_req     out  fetch request (high for the whole S_FETCH state)
//   imem_addr    out  fetch address, always equal to pc
//   imem_valid   in   memory returns data this cycle (meaningful only with req)
//   imem_rdata   in   instruction data
//   stall        in   downstream cannot accept the held instruction
//   redirect     in   load redirect_pc, flush the held or pending fetch
//   redirect_pc  in   redirect target
//   instr_valid  out  instr and its fields are valid for decode
//   instr        out  held instruction, forced to 8'h00 when not valid
//   opcode       out  instr[7:6]
//   rd           out  instr[5:4]
//   rs           out  instr[3:2]
//   rt           out  instr[1:0]
//   instr_pc     out  address the held instruction came from
//   fsmState     out  debug view of the FSM: 0 = S_FETCH, 1 = S_HOLD
//   fetch_count  out  (FETCH_PERF_CNT_EN) consumed instructions
//   stall_count  out  (FETCH_PERF_CNT_EN) cycles spent holding under stall
//
// Handshakes:
//   Memory side:  imem_req and imem_addr stay high and stable until the cycle
//                 in which imem_valid=1. That cycle transfers imem_rdata.
//                 Only one request is ever outstanding.
//   Decode side:  instr_valid plays the role of "valid" and ~stall plays the
//                 role of "ready". The instruction is consumed on an edge
//                 where instr_valid=1 and stall=0. While stalled, the held
//                 instruction is kept stable.
//   redirect overrides both handshakes in the cycle it is asserted.
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_valid,
  input  logic [7:0]          imem_rdata,
  input  logic                stall,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                instr_valid,
  output logic [7:0]          instr,
  output logic [1:0]          opcode,
  output logic [1:0]          rd,
  output logic [1:0]          rs,
  output logic [1:0]          rt,
  output logic [PC_WIDTH-1:0] instr_pc,
  output logic                fsmState
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]         fetch_count,
  output logic [15:0]         stall_count
`endif
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  state_t              state;
  state_t              stateNext;
  logic [PC_WIDTH-1:0] pc;
  logic [7:0]          instrReg;
  logic [PC_WIDTH-1:0] instrPcReg;

  // A fetch completes only when memory answers and no redirect discards it.
  logic fetchDone;
  // The held instruction leaves the stage without being flushed.
  logic consumed;

  assign fetchDone = (state == S_FETCH) && imem_valid && !redirect;
  assign consumed  = (state == S_HOLD) && !stall && !redirect;

  // Next-state logic
  always_comb begin
    stateNext = state;
    if (redirect) begin
      stateNext = S_FETCH;
    end else begin
      case (state)
        S_FETCH: if (imem_valid) stateNext = S_HOLD;
        S_HOLD:  if (!stall)     stateNext = S_FETCH;
        default:                 stateNext = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= stateNext;
    end
  end

  // Datapath: PC and instruction register
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      instrReg   <= 8'h00;
      instrPcReg <= '0;
    end else if (redirect) begin
      pc <= redirect_pc;
    end else if (fetchDone) begin
      instrReg   <= imem_rdata;
      instrPcReg <= pc;
      pc         <= pc + PC_WIDTH'(1);  // wraps modulo 2^PC_WIDTH
    end
  end

  // Outputs: only state and registers, never imem_rdata directly.
  assign imem_req    = (state == S_FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == S_HOLD);
  // An invalid slot reads as opcode 00 (NOP), so decode needs no extra gating.
  assign instr       = instr_valid ? instrReg : 8'h00;
  assign opcode      = instr[7:6];
  assign rd          = instr[5:4];
  assign rs          = instr[3:2];
  assign rt          = instr[1:0];
  assign instr_pc    = instrPcReg;
  assign fsmState    = state;

`ifdef FETCH_PERF_CNT_EN
  logic stallCycle;
  assign stallCycle = (state == S_HOLD) && stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= 16'h0000;
      stall_count <= 16'h0000;
    end else begin
      if (consumed && (fetch_count != 16'hFFFF)) begin
        fetch_count <= fetch_count + 16'd1;
      end
      if (stallCycle && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
    end
  end
`else
  // Without the counters, "consumed" has no reader. Fold it into a dead
  // signal so the build stays warning-free.
  logic unusedConsumed;
  assign unusedConsumed = consumed;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic       clk = 1'b0;
  logic       rst;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_valid;
  logic [7:0] imem_rdata;
  logic       stall;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic       instr_valid;
  logic [7:0] instr;
  logic [1:0] opcode;
  logic [1:0] rd;
  logic [1:0] rs;
  logic [1:0] rt;
  logic [7:0] instr_pc;
  logic       fsmState;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count;
  logic [15:0] stall_count;
`endif

  int total = 0;
  int bad   = 0;

  // Memory model: mem[a] = a ^ memKey, answering after waitCycles cycles.
  logic [7:0] memKey = 8'h00;
  int         waitCycles = 0;
  int         memCnt = 0;
  logic [7:0] memLastAddr = 8'h00;

  instruction_fetch #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .opcode      (opcode),
    .rd          (rd),
    .rs          (rs),
    .rt          (rt),
    .instr_pc    (instr_pc),
    .fsmState    (fsmState)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count (fetch_count),
    .stall_count (stall_count)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  function automatic logic [7:0] memf(input logic [7:0] a);
    return a ^ memKey;
  endfunction

  // ---------------- memory responder (drives on the falling edge) ----------------
  initial begin
    imem_valid = 1'b0;
    imem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (!imem_req || rst) begin
        imem_valid = 1'b0;
        imem_rdata = 8'($urandom);
        memCnt     = 0;
      end else begin
        if (imem_addr !== memLastAddr) memCnt = 0;
        memLastAddr = imem_addr;
        if (memCnt >= waitCycles) begin
          imem_valid = 1'b1;
          imem_rdata = memf(imem_addr);
        end else begin
          imem_valid = 1'b0;
          imem_rdata = 8'($urandom);
        end
        memCnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in S_FETCH at pc=0, one step past the release edge.
  task automatic do_reset;
    stall    = 1'b0;
    redirect = 1'b0;
    rst      = 1'b1;
    tick;
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    memKey = 8'h3C; waitCycles = 0;
    do_reset;
    tick;                       // fetch of address 0 completes, now holding
    stall = 1'b1;
    rst   = 1'b1;
    tick;
    total++;
    if (instr_valid !== 1'b0 || instr !== 8'h00 || instr_pc !== 8'h00 ||
        imem_req !== 1'b1 || imem_addr !== 8'h00) begin
      bad++;
      $display("FAIL reset_from_hold: valid=%b instr=%h ipc=%h req=%b addr=%h, need 0 00 00 1 00",
               instr_valid, instr, instr_pc, imem_req, imem_addr);
    end
    rst = 1'b0; stall = 1'b0;
    tick;
    total++;
    if (instr_valid !== 1'b1 || instr !== memf(8'h00) || instr_pc !== 8'h00) begin
      bad++;
      $display("FAIL reset_first_fetch: valid=%b instr=%h ipc=%h, need 1 %h 00",
               instr_valid, instr, instr_pc, memf(8'h00));
    end
  endtask

  task automatic test_zero_wait;
    logic [7:0] p;
    logic [7:0] e;
    memKey = 8'hA5; waitCycles = 0;
    do_reset;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (imem_req !== 1'b1 || imem_addr !== p || instr_valid !== 1'b0 || instr !== 8'h00) begin
        bad++;
        $display("FAIL zw_fetch i=%0d: req=%b addr=%h valid=%b instr=%h, need 1 %h 0 00",
                 i, imem_req, imem_addr, instr_valid, instr, p);
      end
      tick;
      e = p ^ 8'hA5;
      total++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== e || instr_pc !== p ||
          {opcode, rd, rs, rt} !== e) begin
        bad++;
        $display("FAIL zw_hold i=%0d: valid=%b req=%b instr=%h ipc=%h fields=%b, need 1 0 %h %h",
                 i, instr_valid, imem_req, instr, instr_pc, {opcode, rd, rs, rt}, e, p);
      end
      if (p == 8'h03) begin
        total++;
        if (instr !== 8'hA6 || opcode !== 2'b10 || rd !== 2'b10 || rs !== 2'b01 || rt !== 2'b10) begin
          bad++;
          $display("FAIL zw_pc3: instr=%h op=%b rd=%b rs=%b rt=%b, need a6 10 10 01 10",
                   instr, opcode, rd, rs, rt);
        end
      end
      tick;
      p = p + 8'd1;
    end
  endtask

  task automatic test_wait_states;
    logic [7:0] p;
    memKey = 8'($urandom); waitCycles = 3;
    do_reset;
    p = 8'h00;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (imem_req !== 1'b1 || imem_addr !== p || instr_valid !== 1'b0) begin
          bad++;
          $display("FAIL wait_req f=%0d k=%0d: req=%b addr=%h valid=%b, need 1 %h 0",
                   f, k, imem_req, imem_addr, instr_valid, p);
        end
        tick;
      end
      total++;
      if (instr_valid !== 1'b1 || instr !== memf(p) || instr_pc !== p) begin
        bad++;
        $display("FAIL wait_data f=%0d: valid=%b instr=%h ipc=%h, need 1 %h %h",
                 f, instr_valid, instr, instr_pc, memf(p), p);
      end
      tick;
      p = p + 8'd1;
    end
    waitCycles = 0;
  endtask

  task automatic test_stall;
    logic [7:0] a;
    waitCycles = 0;
    do_reset;
    a = 8'($urandom_range(1, 250));
    memKey = a ^ 8'h7C;
    redirect = 1'b1; redirect_pc = a;
    tick;
    redirect = 1'b0;
    stall    = 1'b1;
    tick;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (instr_valid !== 1'b1 || instr !== 8'h7C || opcode !== 2'b01 ||
          instr_pc !== a || imem_req !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold i=%0d: valid=%b instr=%h op=%b ipc=%h req=%b, need 1 7c 01 %h 0",
                 i, instr_valid, instr, opcode, instr_pc, imem_req, a);
      end
      if (i < 5) tick;
    end
    stall = 1'b0;
    tick;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== a + 8'd1 || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall_next: req=%b addr=%h valid=%b, need 1 %h 0",
               imem_req, imem_addr, instr_valid, a + 8'd1);
    end
  endtask

  task automatic test_redirect;
    memKey = 8'($urandom); waitCycles = 0;
    do_reset;
    tick;                                   // holding instruction from 0
    stall = 1'b1; redirect = 1'b1; redirect_pc = 8'h40;
    tick;
    total++;
    if (instr_valid !== 1'b0 || instr !== 8'h00 || imem_req !== 1'b1 || imem_addr !== 8'h40) begin
      bad++;
      $display("FAIL redir_hold: valid=%b instr=%h req=%b addr=%h, need 0 00 1 40",
               instr_valid, instr, imem_req, imem_addr);
    end
    stall = 1'b0;                           // redirect again, memory answers now
    tick;
    total++;
    if (instr_valid !== 1'b0 || instr !== 8'h00 || imem_req !== 1'b1 || imem_addr !== 8'h40) begin
      bad++;
      $display("FAIL redir_fetch: valid=%b instr=%h req=%b addr=%h, need 0 00 1 40",
               instr_valid, instr, imem_req, imem_addr);
    end
    redirect = 1'b0;
    tick;
    total++;
    if (instr_valid !== 1'b1 || instr !== memf(8'h40) || instr_pc !== 8'h40) begin
      bad++;
      $display("FAIL redir_target: valid=%b instr=%h ipc=%h, need 1 %h 40",
               instr_valid, instr, instr_pc, memf(8'h40));
    end
  endtask

  task automatic test_wrap;
    logic [7:0] p;
    memKey = 8'($urandom); waitCycles = 0;
    do_reset;
    redirect = 1'b1; redirect_pc = 8'hFE;
    tick;
    redirect = 1'b0;
    p = 8'hFE;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (imem_req !== 1'b1 || imem_addr !== p) begin
        bad++;
        $display("FAIL wrap_addr i=%0d: req=%b addr=%h, need 1 %h", i, imem_req, imem_addr, p);
      end
      tick;
      total++;
      if (instr_valid !== 1'b1 || instr_pc !== p || instr !== memf(p)) begin
        bad++;
        $display("FAIL wrap_hold i=%0d: valid=%b ipc=%h instr=%h, need 1 %h %h",
                 i, instr_valid, instr_pc, instr, p, memf(p));
      end
      tick;
      p = p + 8'd1;
    end
  endtask

  // Stream-level reference: instructions are consumed in address order,
  // a redirect restarts the stream at redirect_pc.
  task automatic test_random;
    logic [7:0] exp_q[$];
    logic [7:0] modelPc;
    logic [7:0] e;
    logic       wasValid;
    int         consumes;
    int         stalls;
    memKey = 8'($urandom); waitCycles = 0;
    do_reset;
    modelPc  = 8'h00;
    exp_q    = {};
    exp_q.push_back(memf(modelPc));
    consumes = 0;
    stalls   = 0;
    for (int c = 0; c < 400; c++) begin
      total++;
      if ((imem_req === instr_valid) || (fsmState !== instr_valid) ||
          (imem_req === 1'b1 && imem_addr !== modelPc)) begin
        bad++;
        $display("FAIL rnd_fetch c=%0d: req=%b valid=%b dbg=%b addr=%h, need addr %h",
                 c, imem_req, instr_valid, fsmState, imem_addr, modelPc);
      end
      e = exp_q[0];
      total++;
      if (instr_valid === 1'b1) begin
        if (instr !== e || instr_pc !== modelPc || opcode !== e[7:6] || rd !== e[5:4] ||
            rs !== e[3:2] || rt !== e[1:0]) begin
          bad++;
          $display("FAIL rnd_instr c=%0d: instr=%h ipc=%h, need %h %h",
                   c, instr, instr_pc, e, modelPc);
        end
      end else if (instr !== 8'h00 || {opcode, rd, rs, rt} !== 8'h00) begin
        bad++;
        $display("FAIL rnd_idle c=%0d: instr=%h, need 00", c, instr);
      end
      wasValid    = instr_valid;
      stall       = ($urandom_range(0, 2) == 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = 8'($urandom);
      waitCycles  = $urandom_range(0, 2);
      tick;
      if (wasValid && stall) stalls++;
      if (redirect) begin
        modelPc = redirect_pc;
        exp_q.delete();
        exp_q.push_back(memf(modelPc));
      end else if (wasValid && !stall) begin
        consumes++;
        void'(exp_q.pop_front());
        modelPc = modelPc + 8'd1;
        exp_q.push_back(memf(modelPc));
      end
    end
    total++;
    if (consumes < 20) begin
      bad++;
      $display("FAIL rnd_progress: consumed=%0d, need at least 20", consumes);
    end
`ifdef FETCH_PERF_CNT_EN
    total++;
    if (fetch_count !== 16'(consumes) || stall_count !== 16'(stalls)) begin
      bad++;
      $display("FAIL rnd_counters: fetch=%0d stall=%0d, need %0d %0d",
               fetch_count, stall_count, consumes, stalls);
    end
`endif
    stall = 1'b0; redirect = 1'b0; waitCycles = 0;
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf_counters;
    memKey = 8'($urandom); waitCycles = 0;
    do_reset;
    total++;
    if (fetch_count !== 16'd0 || stall_count !== 16'd0) begin
      bad++;
      $display("FAIL perf_reset: fetch=%0d stall=%0d, need 0 0", fetch_count, stall_count);
    end
    for (int i = 0; i < 10; i++) begin
      tick;                                 // fetch completes
      if (i == 3) begin
        stall = 1'b1;
        repeat (4) tick;
        stall = 1'b0;
      end
      tick;                                 // consumed
    end
    total++;
    if (fetch_count !== 16'd10 || stall_count !== 16'd4) begin
      bad++;
      $display("FAIL perf_counts: fetch=%0d stall=%0d, need 10 4", fetch_count, stall_count);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    total++;
    if (fetch_count !== 16'd0 || stall_count !== 16'd0) begin
      bad++;
      $display("FAIL perf_clear: fetch=%0d stall=%0d, need 0 0", fetch_count, stall_count);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
    repeat (2) tick;
    test_reset;
    test_zero_wait;
    test_wait_states;
    test_stall;
    test_redirect;
    test_wrap;
    test_random;
`ifdef FETCH_PERF_CNT_EN
    test_perf_counters;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
